// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe result checker and its stimulus source.
package pipe_pkg;

  localparam int unsigned TagWidth  = 8;
  localparam int unsigned DataWidth = 32;

  // Galois LFSR feedback taps
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StDone = 2'd1,
    StFail = 2'd2
  } chk_state_e;

  // One Galois LFSR step: shift right, fold taps in when a one drops out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ LfsrTaps) : (cur >> 1);
  endfunction

endpackage

// File: rtl/pipe_check_if.sv
// Retired-item handshake between the last pipe stage and the checker.
interface pipe_check_if;
  import pipe_pkg::*;

  logic                 in_valid;
  logic [TagWidth-1:0]  in_tag;
  logic [DataWidth-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_tag, output in_data, input in_ready);
  modport slave  (input in_valid, input in_tag, input in_data, output in_ready);

endinterface

// File: rtl/pipe_check_lfsr32.sv
// 32-bit Galois LFSR; shared with the upstream source so both ends agree.
module lfsr32
  import pipe_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] state
);

  logic [31:0] state_q;

  // Advance one step per consumed item
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else if (adv) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pipe_check.sv
// Downstream result checker: rotating back-pressure, sequence check, watchdog.
module pipe_check
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 64,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter logic [15:0] STALL_MASK = 16'h0000,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_check_if.slave          up,
  output logic                 test_ended,
  output logic                 test_error,
  output logic [TagWidth-1:0]  err_tag,
  output logic [DataWidth-1:0] err_data
);

  localparam logic [15:0] LastCount = 16'(NUM_ITEMS - 1);
  localparam logic [15:0] IdleLimit = 16'(TIMEOUT - 1);

  chk_state_e           state_q, state_d;
  logic [15:0]          mask_q, mask_d;
  logic [TagWidth-1:0]  exp_tag_q, exp_tag_d;
  logic [15:0]          count_q, count_d;
  logic [15:0]          idle_q, idle_d;
  logic [TagWidth-1:0]  err_tag_q, err_tag_d;
  logic [DataWidth-1:0] err_data_q, err_data_d;
  logic [31:0]          exp_data;
  logic                 acc;
  logic                 mismatch;

  // Ready depends only on registered state, never on in_valid
  assign up.in_ready = (state_q == StRun) & ~mask_q[0];
  assign acc         = up.in_valid & up.in_ready;
  assign mismatch    = (up.in_tag != exp_tag_q) | (up.in_data != exp_data);

  lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (acc),
    .state (exp_data)
  );

  // Next-state: mask rotation, expected tag, counters, verdict
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    exp_tag_d  = exp_tag_q;
    count_d    = count_q;
    idle_d     = idle_q;
    err_tag_d  = err_tag_q;
    err_data_d = err_data_q;
    if (state_q == StRun) begin
      mask_d = {mask_q[0], mask_q[15:1]};
      if (acc) begin
        exp_tag_d = exp_tag_q + 8'd1;
        count_d   = count_q + 16'd1;
        idle_d    = '0;
        // A mismatch on the last item still fails rather than completes
        if (mismatch) begin
          state_d    = StFail;
          err_tag_d  = up.in_tag;
          err_data_d = up.in_data;
        end else if (count_q == LastCount) begin
          state_d = StDone;
        end
      end else begin
        idle_d = idle_q + 16'd1;
        if (idle_q == IdleLimit) begin
          state_d = StFail;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      mask_q     <= STALL_MASK;
      exp_tag_q  <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      err_tag_q  <= '0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      exp_tag_q  <= exp_tag_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      err_tag_q  <= err_tag_d;
      err_data_q <= err_data_d;
    end
  end

  assign test_ended = (state_q != StRun);
  assign test_error = (state_q == StFail);
  assign err_tag    = err_tag_q;
  assign err_data   = err_data_q;

endmodule

// File: doc/pipe_check.md
# pipe_check

Result checker sitting directly downstream of the `pipe` pipeline's final stage. It consumes retired items (tag + data) through a valid/ready handshake and injects back-pressure from a rotating stall mask to exercise pipeline stall control. It compares each item against an internally generated expected sequence, runs a watchdog, and drives the `test_ended` / `test_error` flags seen by the simulation top level.

## Interface
- `NUM_ITEMS`, 64: number of items to accept before the test ends; range 1..65535.
- `SEED`, 32'h0000_0001: initial LFSR state; must be non-zero.
- `STALL_MASK`, 16'h0000: initial rotating back-pressure pattern; bit = 1 means stall.
- `TIMEOUT`, 256: maximum consecutive RUN cycles without an accept; range 2..65535.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, active-low, asynchronous assert, released synchronously by the upstream synchronizer.
- `in_valid` input 1: the pipeline's last stage holds a retired item.
- `in_tag` input 8: item sequence tag.
- `in_data` input 32: item payload.
- `in_ready` output 1: the checker accepts an item this cycle.
- `test_ended` output 1: the test is finished, either passed or failed; sticky.
- `test_error` output 1: the test failed; sticky.
- `err_tag` output 8: tag of the first failing item; 0 on timeout.
- `err_data` output 32: data of the first failing item; 0 on timeout.

## Operation
- Accept: `acc = in_valid & in_ready`. Only accepted items are checked. An item held across stall cycles is checked once.
- States:
  - RUN: reset state.
  - DONE: pass.
  - FAIL: failure.
  - DONE and FAIL are terminal until reset.
- Stall mask:
  - 16-bit `mask` register, reset to `STALL_MASK`.
  - Rotates right by 1 every RUN cycle, whether or not an accept occurs.
  - `in_ready = (state==RUN) & ~mask[0]`.
- Expected tag: 8-bit counter `exp_tag`, reset to 0, increments on each accept and wraps 255→0.
- Expected data:
  - 32-bit Galois LFSR, reset to `SEED`, polynomial taps 32'h8020_0003.
  - Update: `next = lfsr[0] ? (lfsr>>1) ^ TAPS : lfsr>>1`.
  - The item is compared against the current state; the LFSR advances on each accept.
- Item counter: 16-bit `count`, reset to 0, increments on each accept.
- Watchdog:
  - 16-bit `idle`, reset to 0.
  - Clears on accept; otherwise increments in RUN.
  - Counts stalled cycles too, so the mask must not starve the pipeline.
- RUN transitions, checked in priority order each cycle:
  1. Accept with `in_tag != exp_tag` or `in_data != lfsr` → FAIL; capture `in_tag` / `in_data` into `err_tag` / `err_data`.
  2. Good accept with `count == NUM_ITEMS-1` → DONE.
  3. No accept and `idle == TIMEOUT-1` → FAIL; `err_*` stay 0.
- Outputs:
  - `test_ended = (state!=RUN)`.
  - `test_error = (state==FAIL)`.
  - `err_tag` / `err_data` are written only on the first mismatch.
- Reset mid-operation: all registers return to reset values immediately. The next test restarts at tag 0 with LFSR = `SEED`.

## Timing
- Reset values:
  - `in_ready` = ~`STALL_MASK[0]`.
  - `test_ended` = 0, `test_error` = 0, `err_tag` = 0, `err_data` = 0.
- `in_ready` is a function of registered state only; it is never derived combinationally from `in_valid`.
- Latency: a mismatch on an accept at edge N gives FAIL, `test_ended` = 1, `test_error` = 1 and valid `err_*` after edge N.
- A good final accept at edge N gives `test_ended` = 1 after edge N.
- Simultaneous events:
  - A mismatch on the final item → FAIL, not DONE.
  - An accept in the cycle where `idle == TIMEOUT-1` → no timeout.
- `in_ready` = 0 from the first cycle in DONE or FAIL onward.

## Structure
- Shared package `pipe_pkg`:
  - LFSR taps constant 32'h8020_0003.
  - State encoding RUN=2'd0, DONE=2'd1, FAIL=2'd2, as localparams or a typedef.
  - Tag width 8 and data width 32.
- Sub-module `lfsr32`:
  - Ports: `clk`, `rst`, `adv`, `state[31:0]`.
  - Parameter `SEED`.
  - Reused by the upstream stimulus source so both ends generate identical sequences.

## Test plan
1. `NUM_ITEMS`=4, `STALL_MASK`=0, correct items tag 0..3 with data SEED, 32'h8020_0003, …, `in_valid` held high → 4 accepts in 4 cycles; `test_ended`=1 and `test_error`=0 after the 4th edge; `in_ready`=0 afterwards.
2. Item 2 data XOR 1 → FAIL after that edge; `err_tag`=2, `err_data`=corrupted value; item 3 is never accepted.
3. `STALL_MASK`=16'h5555, `in_valid` held → `in_ready` = 0,1,0,1,…; each item is accepted exactly once; `count`=`NUM_ITEMS` at DONE with no error.
4. `TIMEOUT`=8, `in_valid`=0 after reset → FAIL at cycle 8 after reset release; `err_tag`=0, `err_data`=0.
5. Tag sequence 0,1,3 with correct data → FAIL on the third accept, `err_tag`=3.
6. `rst` asserted after 2 good accepts, then released, then items from tag 0 / SEED → flags cleared during reset; the test passes with no error.
